// File: rtl/tagged_normalize_if.sv
// rtl/tagged_normalize_if.sv - valid/ready bus for tagged_normalize.
// tdp_in = {tag, x, y, z, pow_x, pow_y, pow_z}; dir_out = {tag, x, y, z}.
interface tagged_normalize_if #(
   parameter int WIDTH    = 32,
   parameter int TAG_SIZE = 64
);
   localparam int DIR_W = TAG_SIZE + 3*WIDTH;
   localparam int POW_W = DIR_W + 3*WIDTH;

   logic             in_valid;
   logic             in_ready;
   logic [POW_W-1:0] tdp_in;
   logic             out_valid;
   logic             out_ready;
   logic [DIR_W-1:0] dir_out;
   logic             zero_len;
   logic             sat;

   modport slave (
      input  in_valid, tdp_in, out_ready,
      output in_ready, out_valid, dir_out, zero_len, sat
   );

   modport master (
      output in_valid, tdp_in, out_ready,
      input  in_ready, out_valid, dir_out, zero_len, sat
   );
endinterface

// File: rtl/tagged_normalize.sv
// rtl/tagged_normalize.sv - normalizes a tagged direction to unit length.
// Bit-serial sqrt of the summed squares, restoring reciprocal, then one scaling cycle.
module tagged_normalize #(
   parameter int WIDTH    = 32,
   parameter int Q_BITS   = 16,
   parameter int TAG_SIZE = 64
) (
   input  logic           clk,
   input  logic           rst,
   tagged_normalize_if.slave tn
);
   localparam int SQ_ITERS = (WIDTH + Q_BITS + 3) / 2;
   localparam int RAD_W    = 2 * SQ_ITERS;
   localparam int S_W      = WIDTH + 2;
   localparam int RW       = SQ_ITERS + 3;
   localparam int DRW      = WIDTH + 1;
   localparam int DIV_W    = WIDTH + 2*Q_BITS + 1;
   localparam int DIR_W    = TAG_SIZE + 3*WIDTH;

   localparam logic [DIV_W-1:0] DIVIDEND  = {{(DIV_W-1){1'b0}}, 1'b1} << (2*Q_BITS);
   localparam logic [DRW-1:0]   DREM_INIT = DRW'(DIVIDEND >> WIDTH);
   localparam logic [WIDTH-1:0] DSH_INIT  = DIVIDEND[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_SUM, S_SQRT, S_DIV, S_MUL, S_DONE} state_t;

   state_t              state_q;
   logic [7:0]          cnt_q;
   logic [TAG_SIZE-1:0] tag_q;
   logic [WIDTH-1:0]    x_q, y_q, z_q, px_q, py_q, pz_q;
   logic [RAD_W-1:0]    rad_q;
   logic [RW-1:0]       rem_q;
   logic [SQ_ITERS-1:0] root_q;
   logic [DRW-1:0]      drem_q;
   logic [WIDTH-1:0]    dsh_q, quot_q, recip_q;
   logic                rsat_q;
   logic                in_ready_q, out_valid_q, zero_q, sat_q;
   logic [DIR_W-1:0]    dir_q;

   logic [S_W-1:0]      s_d;
   logic [RW-1:0]       rem_sh, trial, rem_d;
   logic [SQ_ITERS-1:0] root_d;
   logic [DRW-1:0]      drem_sh, len_ext, drem_d;
   logic [WIDTH-1:0]    quot_d;
   logic [WIDTH:0]      sx_d, sy_d, sz_d;

   // Returns {clamped, value}: (c * r) >>> Q_BITS saturated to a signed WIDTH result.
   function automatic logic [WIDTH:0] scale(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] r);
      logic signed [2*WIDTH-1:0] p;
      p = $signed({{WIDTH{c[WIDTH-1]}}, c}) * $signed({{WIDTH{r[WIDTH-1]}}, r});
      p = p >>> Q_BITS;
      if ((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]))
         scale = {1'b0, p[WIDTH-1:0]};
      else
         scale = {1'b1, p[2*WIDTH-1] ? MIN_NEG : MAX_POS};
   endfunction

   always_comb begin
      s_d     = S_W'(px_q) + S_W'(py_q) + S_W'(pz_q);
      rem_sh  = RW'({rem_q, rad_q[RAD_W-1 -: 2]});
      trial   = RW'({root_q, 2'b01});
      rem_d   = rem_sh;
      root_d  = SQ_ITERS'({root_q, 1'b0});
      if (rem_sh >= trial) begin
         rem_d  = rem_sh - trial;
         root_d = SQ_ITERS'({root_q, 1'b1});
      end
      drem_sh = DRW'({drem_q, dsh_q[WIDTH-1]});
      len_ext = DRW'(root_q);
      drem_d  = drem_sh;
      quot_d  = WIDTH'({quot_q, 1'b0});
      if (drem_sh >= len_ext) begin
         drem_d = drem_sh - len_ext;
         quot_d = WIDTH'({quot_q, 1'b1});
      end
      sx_d = scale(x_q, recip_q);
      sy_d = scale(y_q, recip_q);
      sz_d = scale(z_q, recip_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tag_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         pz_q        <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         drem_q      <= '0;
         dsh_q       <= '0;
         quot_q      <= '0;
         recip_q     <= '0;
         rsat_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         sat_q       <= 1'b0;
         dir_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tn.in_valid) begin
                  tag_q      <= tn.tdp_in[DIR_W+3*WIDTH-1 -: TAG_SIZE];
                  x_q        <= tn.tdp_in[6*WIDTH-1 -: WIDTH];
                  y_q        <= tn.tdp_in[5*WIDTH-1 -: WIDTH];
                  z_q        <= tn.tdp_in[4*WIDTH-1 -: WIDTH];
                  px_q       <= tn.tdp_in[3*WIDTH-1 -: WIDTH];
                  py_q       <= tn.tdp_in[2*WIDTH-1 -: WIDTH];
                  pz_q       <= tn.tdp_in[WIDTH-1:0];
                  in_ready_q <= 1'b0;
                  state_q    <= S_SUM;
               end
            end
            S_SUM: begin
               if (s_d == '0) begin
                  dir_q       <= {tag_q, {(3*WIDTH){1'b0}}};
                  zero_q      <= 1'b1;
                  sat_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  rad_q   <= RAD_W'({s_d, {Q_BITS{1'b0}}});
                  rem_q   <= '0;
                  root_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= S_SQRT;
               end
            end
            S_SQRT: begin
               rad_q  <= rad_q << 2;
               rem_q  <= rem_d;
               root_q <= root_d;
               if (cnt_q == 8'(SQ_ITERS-1)) begin
                  cnt_q   <= '0;
                  drem_q  <= DREM_INIT;
                  dsh_q   <= DSH_INIT;
                  quot_q  <= '0;
                  state_q <= S_DIV;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DIV: begin
               drem_q <= drem_d;
               dsh_q  <= dsh_q << 1;
               quot_q <= quot_d;
               if (cnt_q == 8'(WIDTH-1)) begin
                  cnt_q   <= '0;
                  recip_q <= quot_d[WIDTH-1] ? MAX_POS : quot_d;
                  rsat_q  <= quot_d[WIDTH-1];
                  state_q <= S_MUL;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_MUL: begin
               dir_q       <= {tag_q, sx_d[WIDTH-1:0], sy_d[WIDTH-1:0], sz_d[WIDTH-1:0]};
               zero_q      <= 1'b0;
               sat_q       <= rsat_q | sx_d[WIDTH] | sy_d[WIDTH] | sz_d[WIDTH];
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (tn.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tn.in_ready  = in_ready_q;
   assign tn.out_valid = out_valid_q;
   assign tn.dir_out   = dir_q;
   assign tn.zero_len  = zero_q;
   assign tn.sat       = sat_q;
endmodule

// File: tb/tb_tagged_normalize.sv
// tb/tb_tagged_normalize.sv - scoreboard bench for tagged_normalize.
// Driver pushes hand-computed results; a negedge monitor pops and compares.
module tb_tagged_normalize;
   logic clk;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   seen = 0;

   typedef struct {
      logic [63:0] tag;
      logic [31:0] x, y, z;
      logic        zl, st;
      int          cap;
      int          lat;
   } exp_t;

   exp_t sbq[$];

   tagged_normalize_if #(.WIDTH(32), .TAG_SIZE(64)) tn_if();

   tagged_normalize #(.WIDTH(32), .Q_BITS(16), .TAG_SIZE(64)) dut (
      .clk (clk),
      .rst (rst),
      .tn  (tn_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         seen = 0;
      end else begin
         if (tn_if.out_valid && !seen) begin
            seen = 1;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output actual=valid required=idle dir=%h", tn_if.dir_out);
            end else begin
               e = sbq[0];
               chk("out_tag", tn_if.dir_out[159:96], e.tag);
               chk("out_x", 64'(tn_if.dir_out[95:64]), 64'(e.x));
               chk("out_y", 64'(tn_if.dir_out[63:32]), 64'(e.y));
               chk("out_z", 64'(tn_if.dir_out[31:0]), 64'(e.z));
               chk("zero_len", 64'(tn_if.zero_len), 64'(e.zl));
               chk("sat", 64'(tn_if.sat), 64'(e.st));
               chk("latency", 64'(cyc - e.cap), 64'(e.lat));
            end
         end
         if (tn_if.out_valid && tn_if.out_ready) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            seen = 0;
         end
      end
   end

   task automatic send(input logic [63:0] tag, input logic [31:0] x, y, z, px, py, pz,
                       input logic [31:0] ex, ey, ez, input logic ezl, est, input int lat,
                       input bit push);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      tn_if.in_valid = 1'b1;
      tn_if.tdp_in   = {tag, x, y, z, px, py, pz};
      n = 0;
      @(negedge clk);
      while (!tn_if.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!tn_if.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_accept actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk); #1;
      tn_if.in_valid = 1'b0;
      if (push) begin
         e.tag = tag; e.x = ex; e.y = ey; e.z = ez;
         e.zl = ezl; e.st = est; e.cap = cyc; e.lat = lat;
         sbq.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic chk_reset_outputs(input string tagname);
      chk({tagname, "_in_ready"}, 64'(tn_if.in_ready), 64'd1);
      chk({tagname, "_out_valid"}, 64'(tn_if.out_valid), 64'd0);
      chk({tagname, "_dir_out_hi"}, tn_if.dir_out[159:96], 64'd0);
      chk({tagname, "_dir_out_lo"}, 64'(tn_if.dir_out[95:0] != 96'd0), 64'd0);
      chk({tagname, "_zero_len"}, 64'(tn_if.zero_len), 64'd0);
      chk({tagname, "_sat"}, 64'(tn_if.sat), 64'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      exp_t e;
      clk = 0;
      rst = 1;
      tn_if.in_valid  = 0;
      tn_if.tdp_in    = '0;
      tn_if.out_ready = 1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 0;

      // Abort a vector in the middle of the square root.
      send(64'hA1, 32'h00010000, 0, 0, 32'h00010000, 0, 0, 0, 0, 0, 0, 0, 59, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("busy_in_ready", 64'(tn_if.in_ready), 64'd0);
      chk("busy_out_valid", 64'(tn_if.out_valid), 64'd0);
      #1 rst = 1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(tn_if.in_ready), 64'd1);
      repeat (80) @(negedge clk);
      chk("post_rst_no_output", 64'(tn_if.out_valid), 64'd0);

      send(64'h0000_0000_0000_00A1, 32'h00010000, 0, 0, 32'h00010000, 0, 0,
           32'h00010000, 0, 0, 0, 0, 59, 1);
      drain();
      send(64'hDEAD_BEEF_0123_4567, 32'h00030000, 32'h00040000, 0, 32'h00090000, 32'h00100000, 0,
           32'h00009999, 32'h0000CCCC, 0, 0, 0, 59, 1);
      drain();
      send(64'h3, 32'hFFFE0000, 0, 0, 32'h00040000, 0, 0,
           32'hFFFF0000, 0, 0, 0, 0, 59, 1);
      drain();
      send(64'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      drain();
      send(64'hA5A5_A5A5_5A5A_5A5A, 32'h00008000, 32'hFFFF8000, 0, 32'h00004000, 32'h00004000, 0,
           32'h0000B505, 32'hFFFF4AFA, 0, 0, 0, 59, 1);
      drain();
      send(64'h6, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h1, 0, 0,
           32'h7FFFFFFF, 32'h80000000, 32'h00000100, 0, 1, 59, 1);
      drain();

      // Backpressure: hold the result, offer a second vector while busy.
      @(posedge clk); #1;
      tn_if.out_ready = 0;
      send(64'hDEAD_BEEF_0123_4567, 32'h00030000, 32'h00040000, 0, 32'h00090000, 32'h00100000, 0,
           32'h00009999, 32'h0000CCCC, 0, 0, 0, 59, 1);
      n = 0;
      @(negedge clk);
      while (!tn_if.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 64'(tn_if.out_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            tn_if.in_valid = 1'b1;
            tn_if.tdp_in   = {64'h0000_0000_0000_00B2, 32'h00010000, 32'h0, 32'h0,
                              32'h00010000, 32'h0, 32'h0};
         end
         @(negedge clk);
         chk("bp_hold_x", 64'(tn_if.dir_out[95:64]), 64'h9999);
         chk("bp_hold_y", 64'(tn_if.dir_out[63:32]), 64'hCCCC);
         chk("bp_hold_tag", tn_if.dir_out[159:96], 64'hDEAD_BEEF_0123_4567);
         chk("bp_hold_valid", 64'(tn_if.out_valid), 64'd1);
         chk("bp_hold_in_ready", 64'(tn_if.in_ready), 64'd0);
      end
      @(posedge clk); #1;
      tn_if.out_ready = 1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(tn_if.in_ready), 64'd0);
      @(negedge clk);
      chk("bp_idle_in_ready", 64'(tn_if.in_ready), 64'd1);
      chk("bp_idle_out_valid", 64'(tn_if.out_valid), 64'd0);
      @(posedge clk); #1;
      tn_if.in_valid = 1'b0;
      e.tag = 64'h0000_0000_0000_00B2; e.x = 32'h00010000; e.y = 0; e.z = 0;
      e.zl = 0; e.st = 0; e.cap = cyc; e.lat = 59;
      sbq.push_back(e);
      @(negedge clk);
      chk("bp_second_busy", 64'(tn_if.in_ready), 64'd0);
      drain();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tagged_normalize.md
Name: tagged_normalize

Overview:
Downstream consumer of the direction-squaring stage in the ray-direction normalization path. Accepts a TaggedDirection_pow, which carries the original tagged direction plus its per-component squares, and computes the length with an iterative bit-serial square root. It then forms the reciprocal with iterative restoring division and emits the unit-length TaggedDirection with its tag unchanged. Multi-cycle, one vector in flight, valid/ready on both sides.

Parameters:
WIDTH, `WIDTH (32), signed fixed-point component width
Q_BITS, `Q_BITS (16), fractional bits of every component
TAG_SIZE, 64, ray tag width carried through untouched
SQ_ITERS, (WIDTH+Q_BITS+3)/2 (25), square-root iterations; derived, do not override

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  tdp_in valid
in_ready  out  1  block can accept
tdp_in  in  TaggedDirection_pow  .direction = TaggedDirection (tag + xyz); .pow.x/y/z = squares, Q format
out_valid  out  1  dir_out valid
out_ready  in  1  consumer accepts
dir_out  out  TaggedDirection  normalized direction, same tag
zero_len  out  1  qualifies dir_out: input length was zero
sat  out  1  qualifies dir_out: reciprocal or a product was clamped

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - State IDLE; in_ready=1; out_valid=0.
  - dir_out=0, zero_len=0, sat=0.
  - All internal accumulators and counters are 0.
- States: IDLE, SUM, SQRT, DIV, MUL, DONE.
- IDLE:
  - in_ready=1. On in_valid, capture tdp_in (the capture edge) and go to SUM.
  - in_ready=0 in every other state.
- SUM (1 cycle):
  - s = pow.x+pow.y+pow.z, unsigned, WIDTH+2 bits, no overflow possible.
  - If s==0: register dir_out.tag=tag, xyz=0, zero_len=1, sat=0; go to DONE. out_valid rises 1 edge after the capture edge.
  - Otherwise register radicand R = s << Q_BITS (WIDTH+Q_BITS+2 bits, zero-extended to 2*SQ_ITERS) and go to SQRT.
- SQRT (SQ_ITERS cycles):
  - Restoring integer square root, one root bit per cycle, MSB first.
  - len = floor(sqrt(R)), a Q_BITS-fractional value.
  - An iteration counter counts 0..SQ_ITERS-1, then the FSM goes to DIV.
- DIV (WIDTH cycles):
  - Restoring unsigned division r = floor(2^(2*Q_BITS) / len), one quotient bit per cycle.
  - len is nonzero here by construction.
  - If the quotient exceeds 2^(WIDTH-1)-1, clamp it to that value and set the sat flag.
- MUL (1 cycle):
  - Each output component = (comp * r) >>> Q_BITS.
  - Signed 2*WIDTH-bit product, arithmetic shift, truncation toward negative infinity.
  - Clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clamp sets sat.
  - Register dir_out (tag passed through), zero_len=0, then go to DONE.
- Non-zero latency: out_valid rises 2+SQ_ITERS+WIDTH edges after the capture edge (59 at defaults). The latency is fixed and independent of the data.
- DONE:
  - out_valid=1; dir_out, zero_len and sat are held stable.
  - Go to IDLE on the edge where out_ready=1.
  - in_ready rises the following cycle: there is no same-cycle turnaround.
  - out_valid must not drop, and the data must not change, while out_ready=0.
- in_valid while busy is ignored. The upstream stage holds its data because in_ready=0.
- Reset mid-operation aborts the vector: the FSM returns to IDLE, outputs return to reset values, and nothing is emitted afterwards.
- Maximum accepted magnitude: if s overflows the caller's range, that is the upstream stage's concern. This block does not detect it.

Test Plan:
- Reset during SQRT (cycle 10 after capture) → out_valid=0, in_ready=1 after reset release, all outputs 0, no later output.
- Input dir (1.0,0,0) = (0x00010000,0,0), pow.x=0x00010000 → len=0x10000, r=0x10000, dir_out=(0x00010000,0,0), out_valid exactly 59 edges after capture, zero_len=0, sat=0.
- Input (3.0,4.0,0), pows (0x90000,0x100000,0) → r=0x3333, dir_out=(0x00009999,0x0000CCCC,0), tag 64'hDEAD_BEEF_0123_4567 preserved.
- Input (-2.0,0,0), pow.x=0x40000 → r=0x8000, dir_out.x=0xFFFF0000, sat=0.
- Zero vector, tag 64'h1 → dir_out xyz=0, zero_len=1, out_valid 1 edge after capture.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → dir_out stable, in_ready=0, and a second in_valid is not captured. When out_ready=1, the block returns to IDLE, and the next vector is captured on the following cycle with correct output.
